// File: rtl/rotary_paddle_input.sv
// Rotary encoder front end for the paddle. It synchronizes and debounces both
// quadrature channels, decodes detents and presents a paddle line that changes at most once per frame.
module rotary_paddle_input #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [9:0]  PADDLE_MIN      = 10'd0,
    parameter logic [9:0]  PADDLE_MAX      = 10'd400,
    parameter logic [9:0]  PADDLE_STEP     = 10'd4,
    parameter logic [9:0]  PADDLE_RESET    = 10'd200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       rota,
    input  logic       rotb,
    input  logic       vsync,
    output logic [9:0] paddle_y,
    output logic       step_pulse,
    output logic       step_dir,
    output logic       illegal_pulse
);

    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q11 = 2'b11,
        Q10 = 2'b10
    } quad_t;

    // Bit 1 is channel A and bit 0 is channel B, so {A,B} reads directly as the state.
    logic [1:0] raw_s;
    logic [1:0] deb_s;

    assign raw_s = {rota, rotb};

    // The saturating moves are done in 11 bits, so a sum near the top cannot wrap.
    function automatic logic [9:0] move_down(input logic [9:0] p);
        logic [10:0] sum_s;
        sum_s = {1'b0, p} + {1'b0, PADDLE_STEP};
        if (sum_s > {1'b0, PADDLE_MAX}) begin
            move_down = PADDLE_MAX;
        end else begin
            move_down = sum_s[9:0];
        end
    endfunction

    function automatic logic [9:0] move_up(input logic [9:0] p);
        if ({1'b0, p} < ({1'b0, PADDLE_MIN} + {1'b0, PADDLE_STEP})) begin
            move_up = PADDLE_MIN;
        end else begin
            move_up = p - PADDLE_STEP;
        end
    endfunction

    genvar ch;
    generate
        for (ch = 0; ch < 2; ch++) begin : g_chan
            logic        s1_r;
            logic        s2_r;
            logic        d_r;
            logic [15:0] c_r;

            // Two-flop synchronizer feeding a run-length debouncer for one channel
            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    s1_r <= 1'b0;
                    s2_r <= 1'b0;
                    d_r  <= 1'b0;
                    c_r  <= 16'd0;
                end else begin
                    s1_r <= raw_s[ch];
                    s2_r <= s1_r;
                    if (s2_r == d_r) begin
                        c_r <= 16'd0;
                    end else if (c_r == (DEBOUNCE_CYCLES - 16'd1)) begin
                        d_r <= s2_r;
                        c_r <= 16'd0;
                    end else begin
                        c_r <= c_r + 16'd1;
                    end
                end
            end

            assign deb_s[ch] = d_r;
        end
    endgenerate

    quad_t      q_r;
    quad_t      q_new_s;
    logic       first_r;
    logic [9:0] pos_r;
    logic       changed_s;
    logic       both_s;
    logic       down_s;
    logic       up_s;
    logic       vsync_r;

    // Classify the move from the held state to the current debounced pair
    always_comb begin
        q_new_s   = quad_t'(deb_s);
        changed_s = (q_new_s != q_r);
        both_s    = ((2'(q_r) ^ 2'(q_new_s)) == 2'b11);
        down_s    = (q_r == Q01) && (q_new_s == Q11);
        up_s      = (q_r == Q10) && (q_new_s == Q11);
    end

    // Quadrature state, the event pulses and the saturating paddle position
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            q_r           <= Q00;
            first_r       <= 1'b1;
            step_pulse    <= 1'b0;
            step_dir      <= 1'b0;
            illegal_pulse <= 1'b0;
            pos_r         <= PADDLE_RESET;
        end else begin
            step_pulse    <= 1'b0;
            illegal_pulse <= 1'b0;
            if (changed_s) begin
                q_r <= q_new_s;
                // The first change only aligns the state to where the encoder rests.
                if (first_r) begin
                    first_r <= 1'b0;
                end else if (both_s) begin
                    illegal_pulse <= 1'b1;
                end else if (down_s) begin
                    step_pulse <= 1'b1;
                    step_dir   <= 1'b1;
                    pos_r      <= move_down(pos_r);
                end else if (up_s) begin
                    step_pulse <= 1'b1;
                    step_dir   <= 1'b0;
                    pos_r      <= move_up(pos_r);
                end
            end
        end
    end

    // Load the frame-stable paddle line once per frame, on the vsync falling edge
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            vsync_r  <= 1'b1;
            paddle_y <= PADDLE_RESET;
        end else begin
            vsync_r <= vsync;
            if (!vsync && vsync_r) begin
                paddle_y <= pos_r;
            end
        end
    end

endmodule

// File: tb/tb_rotary_paddle_input.sv
// Randomized and directed bench for rotary_paddle_input. Each cycle it compares the DUT against a
// reference model built from windowed stability checks and a table of quadrature transitions.
module tb_rotary_paddle_input;

    localparam int N = 8;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       rota;
    logic       rotb;
    logic       vsync;
    logic [9:0] paddle_y;
    logic       step_pulse;
    logic       step_dir;
    logic       illegal_pulse;

    int n_vec = 0;
    int n_err = 0;
    int cnt_step = 0;
    int cnt_ill = 0;
    int fc = 0;

    // Reference model state
    bit raw1[2], raw2[2];
    bit win[2][$];
    bit mdeb[2];
    int mq, mpos, mpy;
    bit mfirst, msp, mil, mdir, mvs;

    rotary_paddle_input #(
        .DEBOUNCE_CYCLES(16'd8),
        .PADDLE_MIN(10'd0),
        .PADDLE_MAX(10'd400),
        .PADDLE_STEP(10'd4),
        .PADDLE_RESET(10'd200)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .rota(rota),
        .rotb(rotb),
        .vsync(vsync),
        .paddle_y(paddle_y),
        .step_pulse(step_pulse),
        .step_dir(step_dir),
        .illegal_pulse(illegal_pulse)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            raw1[c] = 1'b0;
            raw2[c] = 1'b0;
            mdeb[c] = 1'b0;
            win[c].delete();
        end
        mq = 0; mfirst = 1'b1; msp = 1'b0; mil = 1'b0; mdir = 1'b0;
        mpos = 200; mpy = 200; mvs = 1'b1;
    endtask

    task automatic model_step();
        int qd;
        bit s;
        bit all_diff;
        // The frame load takes the position as it stood before this cycle's event.
        if (!vsync && mvs) mpy = mpos;
        mvs = vsync;
        qd = mdeb[1] * 2 + mdeb[0];
        msp = 1'b0;
        mil = 1'b0;
        if (qd != mq) begin
            if (mfirst) mfirst = 1'b0;
            else if ((qd ^ mq) == 3) mil = 1'b1;
            else if (qd == 3 && mq == 1) begin
                msp = 1'b1; mdir = 1'b1; mpos = (mpos + 4 > 400) ? 400 : mpos + 4;
            end else if (qd == 3 && mq == 2) begin
                msp = 1'b1; mdir = 1'b0; mpos = (mpos - 4 < 0) ? 0 : mpos - 4;
            end
            mq = qd;
        end
        // A level is accepted once the last N synchronized samples all disagree with it.
        for (int c = 0; c < 2; c++) begin
            s = raw2[c];
            raw2[c] = raw1[c];
            raw1[c] = (c == 1) ? rota : rotb;
            win[c].push_back(s);
            if (win[c].size() > N) void'(win[c].pop_front());
            all_diff = (win[c].size() == N);
            foreach (win[c][k]) if (win[c][k] == mdeb[c]) all_diff = 1'b0;
            if (all_diff) mdeb[c] = ~mdeb[c];
        end
    endtask

    // Advance the model at each edge and compare all outputs just after it
    initial begin
        forever begin
            @(posedge Clock);
            if (Reset !== 1'b1) model_reset();
            else model_step();
            #1;
            chk("paddle_y", paddle_y, mpy);
            chk("step_pulse", step_pulse, msp);
            chk("step_dir", step_dir, mdir);
            chk("illegal_pulse", illegal_pulse, mil);
            if (step_pulse === 1'b1) cnt_step++;
            if (illegal_pulse === 1'b1) cnt_ill++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge Clock);
            fc = (fc + 1) % 53;
            vsync = (fc < 3) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic detent(input bit down);
        bit [1:0] seq_dn [4];
        bit [1:0] seq_up [4];
        seq_dn = '{2'b10, 2'b00, 2'b01, 2'b11};
        seq_up = '{2'b01, 2'b00, 2'b10, 2'b11};
        for (int p = 0; p < 4; p++) begin
            {rota, rotb} = down ? seq_dn[p] : seq_up[p];
            tick(12);
        end
    endtask

    initial begin
        int ha, hb;
        Reset = 1'b0;
        rota = 1'b1;
        rotb = 1'b1;
        vsync = 1'b1;
        tick(3);
        Reset = 1'b1;
        tick(40);
        chk("reset_paddle", paddle_y, 32'd200);
        chk("model_reset_paddle", mpy, 32'd200);
        chk("reset_no_steps", cnt_step, 32'd0);
        chk("reset_no_illegal", cnt_ill, 32'd0);

        detent(1'b1);
        tick(60);
        chk("one_down_paddle", paddle_y, 32'd204);
        chk("model_one_down", mpy, 32'd204);
        chk("one_down_count", cnt_step, 32'd1);
        chk("one_down_dir", step_dir, 32'd1);

        for (int i = 0; i < 13; i++) begin
            rota = ~rota;
            tick(3);
        end
        rota = 1'b1;
        tick(20);
        chk("bounce_no_step", cnt_step, 32'd1);
        chk("bounce_no_illegal", cnt_ill, 32'd0);

        for (int i = 0; i < 101; i++) detent(1'b1);
        tick(60);
        chk("sat_max_paddle", paddle_y, 32'd400);
        chk("sat_max_count", cnt_step, 32'd102);

        for (int i = 0; i < 110; i++) detent(1'b0);
        tick(60);
        chk("sat_min_paddle", paddle_y, 32'd0);
        chk("sat_min_count", cnt_step, 32'd212);
        chk("sat_min_dir", step_dir, 32'd0);

        {rota, rotb} = 2'b01;
        tick(12);
        {rota, rotb} = 2'b10;
        tick(12);
        chk("illegal_count", cnt_ill, 32'd1);
        chk("illegal_no_step", cnt_step, 32'd212);
        {rota, rotb} = 2'b11;
        tick(70);
        chk("illegal_pos_kept", paddle_y, 32'd0);

        rota = 1'b0;
        tick(5);
        Reset = 1'b0;
        tick(2);
        Reset = 1'b1;
        rota = 1'b1;
        tick(30);
        chk("midreset_paddle", paddle_y, 32'd200);

        ha = 1; hb = 1;
        for (int i = 0; i < 3000; i++) begin
            if (--ha == 0) begin rota = ~rota; ha = $urandom_range(20, 1); end
            if (--hb == 0) begin rotb = ~rotb; hb = $urandom_range(20, 1); end
            if (i == 1500) Reset = 1'b0;
            if (i == 1502) Reset = 1'b1;
            tick(1);
        end
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
